// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          DEF_LATENCY = 2;
  localparam int          DEF_DEPTH   = 64;
  localparam logic [31:0] ERR_DATA    = 32'h0000_0000;

  // A request is legal when it is word aligned and its word index is inside the array.
  function automatic logic adr_legal(input logic [31:0] adr, input int unsigned depth);
    return (adr[1:0] == 2'b00) && ({2'b00, adr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the multi-cycle datapath and the memory responder.
interface mem_responder_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;
  logic        Busy;

  modport master (
    output MemReq, MemWrite, Adr, WriteData,
    input  ReadData, MemReady, MemErr, Busy
  );

  modport slave (
    input  MemReq, MemWrite, Adr, WriteData,
    output ReadData, MemReady, MemErr, Busy
  );
endinterface

// File: rtl/mem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, never reset.
module mem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Word write; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency single-outstanding memory responder: one request in flight,
// WAIT ignores new strobes, RESP can accept the next request back-to-back.
module mem_responder
  import mem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          r_we;
  logic [31:0]   r_adr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_ready;
  logic          r_err;

  logic          w_accept;
  logic          w_enter_resp;
  logic          w_src_we;
  logic [31:0]   w_src_adr;
  logic [31:0]   w_src_wdata;
  logic          w_legal;
  logic [AW-1:0] w_idx;
  logic          w_arr_we;
  logic [31:0]   w_arr_rdata;

  assign w_accept = bus.MemReq && ((r_state == IDLE) || (r_state == RESP));

  // With LATENCY=1 the response edge is the accept edge itself, so the live
  // bus fields are used; otherwise the fields latched at acceptance are used.
  assign w_enter_resp = (LATENCY == 1) ? w_accept : ((r_state == WAIT) && (r_cnt == 4'd0));
  assign w_src_we     = (LATENCY == 1) ? bus.MemWrite  : r_we;
  assign w_src_adr    = (LATENCY == 1) ? bus.Adr       : r_adr;
  assign w_src_wdata  = (LATENCY == 1) ? bus.WriteData : r_wdata;

  assign w_legal  = adr_legal(w_src_adr, DEPTH);
  assign w_idx    = w_src_adr[AW+1:2];
  assign w_arr_we = w_enter_resp && w_src_we && w_legal;

  mem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_waddr (w_idx),
    .i_wdata (w_src_wdata),
    .i_raddr (w_idx),
    .o_rdata (w_arr_rdata)
  );

  // State and latency counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: accept from IDLE/RESP, count down in WAIT, MemReq ignored in WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        if (bus.MemReq) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(LATENCY - 2);
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Request fields captured at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_adr   <= 32'h0;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_we    <= bus.MemWrite;
      r_adr   <= bus.Adr;
      r_wdata <= bus.WriteData;
    end
  end

  // Response registers: one-cycle ready/error pulse, read data held until the next read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= ERR_DATA;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp && !w_legal;
      if (w_enter_resp) begin
        if (!w_legal)      r_rdata <= ERR_DATA;
        else if (!w_src_we) r_rdata <= w_arr_rdata;
      end
    end
  end

  assign bus.ReadData = r_rdata;
  assign bus.MemReady = r_ready;
  assign bus.MemErr   = r_err;
  assign bus.Busy     = (r_state == WAIT);

endmodule
